// File: rtl/vc_trace_pkg.sv
// Shared types and ASCII constants for the line-trace formatter.
// Provides the FSM state enum and the nibble-to-hex helper.
package vc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    SEP
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_BAR   = 8'h7C;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h61;

  function automatic logic [7:0] nibble_to_ascii(logic [3:0] n);
    logic [7:0] w;
    w = {4'h0, n};
    if (n < 4'd10)
      return ASCII_ZERO + w;
    else
      return ASCII_A - 8'd10 + w;
  endfunction

endpackage

// File: rtl/vc_trace_hex_fmt.sv
// Serializes one sampled val/rdy/msg interface into an ASCII trace field.
// Hex digits, '#', '.' or blanks per column, then a '|' separator.
module vc_trace_hex_fmt
  import vc_trace_pkg::*;
#(
  parameter int p_msg_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_val,
  output logic                   cap_rdy,
  input  logic                   mon_val,
  input  logic                   mon_rdy,
  input  logic [p_msg_nbits-1:0] mon_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [7:0]             out_char,
  output logic                   out_last,
  output logic [31:0]            cycles
);

  localparam int NCHARS = (p_msg_nbits + 3) / 4;
  localparam int IW = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam int MW = 4 * NCHARS;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHARS - 1);

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic          c_val;
  logic          c_rdy;
  logic [MW-1:0] c_msg;
  logic          cap_fire;
  logic          out_fire;
  logic          at_top;
  logic [3:0]    nib;
  logic [7:0]    ch;

  assign cap_rdy  = (state == IDLE) && !reset;
  assign cap_fire = cap_val && cap_rdy;
  assign out_val  = (state != IDLE);
  assign out_last = (state == SEP);
  assign out_fire = out_val && out_rdy;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (cap_fire) state_n = EMIT;
      EMIT: if (out_fire && idx == '0) state_n = SEP;
      SEP:  if (out_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      c_val  <= 1'b0;
      c_rdy  <= 1'b0;
      c_msg  <= '0;
      cycles <= '0;
    end else begin
      state <= state_n;
      if (cap_fire) begin
        idx    <= IDX_TOP;
        c_val  <= mon_val;
        c_rdy  <= mon_rdy;
        c_msg  <= MW'(mon_msg);
        cycles <= cycles + 32'd1;
      end else if (state == EMIT && out_fire && idx != '0) begin
        idx <= idx - 1'b1;
      end
    end
  end

  // Only the leftmost column carries the '#' / '.' marker.
  always_comb begin
    nib    = c_msg[{idx, 2'b00} +: 4];
    at_top = (idx == IDX_TOP);
    ch     = ASCII_SPACE;
    unique case (1'b1)
      c_val && c_rdy:  ch = nibble_to_ascii(nib);
      !c_val && c_rdy: ch = ASCII_SPACE;
      c_val && !c_rdy: ch = at_top ? ASCII_HASH : ASCII_SPACE;
      default:         ch = at_top ? ASCII_DOT : ASCII_SPACE;
    endcase
  end

  always_comb begin
    out_char = 8'h00;
    unique case (state)
      EMIT:    out_char = ch;
      SEP:     out_char = ASCII_BAR;
      default: out_char = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vc_trace_hex_fmt.sv
// Scoreboard bench for vc_trace_hex_fmt at 8-bit and 10-bit widths.
// Expected characters are queued at capture and compared on output.
module tb_vc_trace_hex_fmt;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        cap_val = 1'b0;
  logic        cap_rdy;
  logic        mon_val = 1'b0;
  logic        mon_rdy = 1'b0;
  logic [7:0]  mon_msg = 8'h00;
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic [7:0]  out_char;
  logic        out_last;
  logic [31:0] cycles;

  logic        cap_val_b = 1'b0;
  logic        cap_rdy_b;
  logic        mon_val_b = 1'b0;
  logic        mon_rdy_b = 1'b0;
  logic [9:0]  mon_msg_b = 10'h000;
  logic        out_val_b;
  logic        out_rdy_b = 1'b1;
  logic [7:0]  out_char_b;
  logic        out_last_b;
  logic [31:0] cycles_b;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  vc_trace_hex_fmt #(.p_msg_nbits(8)) dut (
    .clk(clk), .reset(reset),
    .cap_val(cap_val), .cap_rdy(cap_rdy),
    .mon_val(mon_val), .mon_rdy(mon_rdy), .mon_msg(mon_msg),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_char(out_char), .out_last(out_last), .cycles(cycles)
  );

  vc_trace_hex_fmt #(.p_msg_nbits(10)) dut_b (
    .clk(clk), .reset(reset),
    .cap_val(cap_val_b), .cap_rdy(cap_rdy_b),
    .mon_val(mon_val_b), .mon_rdy(mon_rdy_b), .mon_msg(mon_msg_b),
    .out_val(out_val_b), .out_rdy(out_rdy_b),
    .out_char(out_char_b), .out_last(out_last_b), .cycles(cycles_b)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_val !== 1'b0 || out_last !== 1'b0 || out_char !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: val=%b last=%b char=%h, want 0 0 00",
               out_val, out_last, out_char);
    end
    checks++;
    if (cycles !== 32'd0 || cap_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cycles=%0d cap_rdy=%b, want 0 0",
               cycles, cap_rdy);
    end
    checks++;
    if (out_val_b !== 1'b0 || cap_rdy_b !== 1'b0 || cycles_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_b: val=%b cap_rdy=%b cycles=%0d, want 0 0 0",
               out_val_b, cap_rdy_b, cycles_b);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cap_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cap_rdy=%b, want 1", cap_rdy);
    end
  endtask

  task automatic test_hex();
    exp_t e;
    int   n;
    cap_val = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1; mon_msg = 8'h3a;
    sb.push_back('{8'h33, 1'b0});
    sb.push_back('{8'h61, 1'b0});
    sb.push_back('{8'h7C, 1'b1});
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk); n++;
      cap_val = 1'b0;
      mon_msg = 8'hc5;
      checks++;
      if (out_val !== 1'b1) begin
        errors++;
        $display("FAIL hex_val: cycle %0d out_val=%b, want 1", n, out_val);
      end else begin
        e = sb.pop_front();
        checks++;
        if (out_char !== e.ch || out_last !== e.last) begin
          errors++;
          $display("FAIL hex_char: got %h/%b, want %h/%b",
                   out_char, out_last, e.ch, e.last);
        end
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL hex_len: line took %0d cycles, want 3", n);
    end
    @(negedge clk);
    checks++;
    if (cap_rdy !== 1'b1 || out_val !== 1'b0 || cycles !== 32'd1) begin
      errors++;
      $display("FAIL hex_end: cap_rdy=%b val=%b cycles=%0d, want 1 0 1",
               cap_rdy, out_val, cycles);
    end
  endtask

  task automatic test_modes();
    logic [7:0] first [3];
    logic       mv [3];
    logic       mr [3];
    exp_t       e;
    int         n;
    mv[0] = 1'b0; mr[0] = 1'b1; first[0] = 8'h20;
    mv[1] = 1'b1; mr[1] = 1'b0; first[1] = 8'h23;
    mv[2] = 1'b0; mr[2] = 1'b0; first[2] = 8'h2E;
    for (int m = 0; m < 3; m++) begin
      cap_val = 1'b1; mon_val = mv[m]; mon_rdy = mr[m]; mon_msg = 8'h3a;
      sb.push_back('{first[m], 1'b0});
      sb.push_back('{8'h20, 1'b0});
      sb.push_back('{8'h7C, 1'b1});
      n = 0;
      while (sb.size() > 0 && n < 20) begin
        @(negedge clk); n++;
        cap_val = 1'b0;
        if (out_val === 1'b1) begin
          e = sb.pop_front();
          checks++;
          if (out_char !== e.ch || out_last !== e.last) begin
            errors++;
            $display("FAIL mode%0d_char: got %h/%b, want %h/%b",
                     m, out_char, out_last, e.ch, e.last);
          end
        end
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL mode%0d_timeout: %0d chars left, want 0",
                 m, sb.size());
        sb.delete();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    exp_t       e;
    int         n;
    pat = 6'b110010;
    cap_val = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1; mon_msg = 8'hf0;
    sb.push_back('{8'h66, 1'b0});
    sb.push_back('{8'h30, 1'b0});
    sb.push_back('{8'h7C, 1'b1});
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      cap_val = 1'b0;
      out_rdy = (n < 6) ? pat[n] : 1'b1;
      n++;
      checks++;
      if (out_val !== 1'b1 || cap_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hs: cycle %0d val=%b cap_rdy=%b, want 1 0",
                 n, out_val, cap_rdy);
      end
      e = sb[0];
      checks++;
      if (out_char !== e.ch || out_last !== e.last) begin
        errors++;
        $display("FAIL bp_char: cycle %0d got %h/%b, want %h/%b",
                 n, out_char, out_last, e.ch, e.last);
      end
      if (out_rdy) void'(sb.pop_front());
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL bp_len: line took %0d cycles, want 6", n);
      sb.delete();
    end
    @(negedge clk);
    out_rdy = 1'b1;
    checks++;
    if (cap_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_end: cap_rdy=%b, want 1", cap_rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0;
    exp_t        e;
    int          n;
    c0 = cycles;
    cap_val = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1; mon_msg = 8'h12;
    sb.push_back('{8'h31, 1'b0});
    sb.push_back('{8'h32, 1'b0});
    sb.push_back('{8'h7C, 1'b1});
    sb.push_back('{8'h39, 1'b0});
    sb.push_back('{8'h63, 1'b0});
    sb.push_back('{8'h7C, 1'b1});
    n = 0;
    while (sb.size() > 0 && n < 30) begin
      @(negedge clk); n++;
      mon_msg = 8'h9c;
      if (n == 2) begin
        checks++;
        if (cycles !== c0 + 32'd1) begin
          errors++;
          $display("FAIL b2b_ignored: cycles=%0d, want %0d", cycles, c0 + 1);
        end
      end
      if (out_val === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (out_char !== e.ch || out_last !== e.last) begin
          errors++;
          $display("FAIL b2b_char: got %h/%b, want %h/%b",
                   out_char, out_last, e.ch, e.last);
        end
      end
    end
    cap_val = 1'b0;
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL b2b_len: two lines took %0d cycles, want 7", n);
      sb.delete();
    end
    @(negedge clk);
    checks++;
    if (cycles !== c0 + 32'd2 || cap_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: cycles=%0d cap_rdy=%b, want %0d 1",
               cycles, cap_rdy, c0 + 2);
    end
  endtask

  task automatic test_wide();
    exp_t e;
    int   n;
    cap_val_b = 1'b1; mon_val_b = 1'b1; mon_rdy_b = 1'b1;
    mon_msg_b = 10'h3ff;
    sb.push_back('{8'h33, 1'b0});
    sb.push_back('{8'h66, 1'b0});
    sb.push_back('{8'h66, 1'b0});
    sb.push_back('{8'h7C, 1'b1});
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk); n++;
      cap_val_b = 1'b0;
      if (out_val_b === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (out_char_b !== e.ch || out_last_b !== e.last) begin
          errors++;
          $display("FAIL wide_char: got %h/%b, want %h/%b",
                   out_char_b, out_last_b, e.ch, e.last);
        end
      end
    end
    checks++;
    if (n != 4 || cycles_b !== 32'd1) begin
      errors++;
      $display("FAIL wide_len: %0d cycles, count=%0d, want 4 1",
               n, cycles_b);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midline();
    exp_t e;
    int   n;
    cap_val = 1'b1; mon_val = 1'b1; mon_rdy = 1'b1; mon_msg = 8'h3a;
    @(negedge clk);
    cap_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_char !== 8'h33) begin
      errors++;
      $display("FAIL rst_first: val=%b char=%h, want 1 33",
               out_val, out_char);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (cap_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_caprdy: cap_rdy=%b during reset, want 0", cap_rdy);
    end
    @(negedge clk);
    checks++;
    if (out_val !== 1'b0 || out_last !== 1'b0 || cycles !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: val=%b last=%b cycles=%0d, want 0 0 0",
               out_val, out_last, cycles);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cap_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_release: cap_rdy=%b, want 1", cap_rdy);
    end
    cap_val = 1'b1; mon_msg = 8'h5e;
    sb.push_back('{8'h35, 1'b0});
    sb.push_back('{8'h65, 1'b0});
    sb.push_back('{8'h7C, 1'b1});
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk); n++;
      cap_val = 1'b0;
      if (out_val === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (out_char !== e.ch || out_last !== e.last) begin
          errors++;
          $display("FAIL rst_fresh: got %h/%b, want %h/%b",
                   out_char, out_last, e.ch, e.last);
        end
      end
    end
    checks++;
    if (n != 3 || cycles !== 32'd1) begin
      errors++;
      $display("FAIL rst_fresh_len: %0d cycles, count=%0d, want 3 1",
               n, cycles);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_hex();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_wide();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_trace_hex_fmt.md
# vc_trace_hex_fmt

Hardware formatter that sits directly upstream of the line-trace storage. It samples one monitored val/rdy/msg interface per traced cycle and serializes it into an ASCII character stream using the `vc_Trace` val/rdy conventions: hex digits, `#`, `.` or blanks, then a column separator. The downstream trace-line assembler or character sink consumes the stream over a val/rdy handshake.

## Interface
- `p_msg_nbits`, default 32: width of the monitored message.
- `NCHARS` (localparam) = (p_msg_nbits+3)/4: hex columns per field.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cap_val` in 1: request to sample the monitored interface this cycle.
- `cap_rdy` out 1: formatter can accept a sample.
- `mon_val` in 1: monitored interface val.
- `mon_rdy` in 1: monitored interface rdy.
- `mon_msg` in p_msg_nbits: monitored interface message.
- `out_val` out 1: character valid.
- `out_rdy` in 1: downstream accepts the character.
- `out_char` out 8: ASCII character.
- `out_last` out 1: current character is the field separator.
- `cycles` out 32: number of accepted samples.

## Operation
- Reset state: IDLE, `out_val`=0, `out_last`=0, `out_char`=0x00, `cycles`=0, `cap_rdy`=0 while `reset` is high.
- FSM states:
  - IDLE: `cap_rdy`=1. When `cap_val`&`cap_rdy`:
    - latch `mon_val`, `mon_rdy` and `mon_msg` into capture registers, zero-extending the message to 4*NCHARS bits;
    - load `idx`=NCHARS-1;
    - increment `cycles` (wraps at 2^32);
    - go to EMIT.
  - EMIT: `out_val`=1 and `out_char`=f(idx). On a transfer (`out_val`&`out_rdy`):
    - if `idx`=0, go to SEP;
    - otherwise decrement `idx`.
  - SEP: `out_val`=1, `out_char`=`|` (0x7C), `out_last`=1. On a transfer, go to IDLE.
- Character function f(idx), selected by the captured val/rdy:
  - val&rdy: hex digit of nibble msg[4*idx+:4], MSB nibble first. 0–9 map to 0x30–0x39; a–f map to lowercase 0x61–0x66.
  - !val&rdy: space (0x20) in every column.
  - val&!rdy: `#` (0x23) at idx=NCHARS-1, space elsewhere.
  - !val&!rdy: `.` (0x2E) at idx=NCHARS-1, space elsewhere.
- Captured values are frozen for the whole line. Changes on `mon_*` after capture have no effect.
- `cap_val` asserted outside IDLE is ignored: no capture and no `cycles` increment. The caller owns drop accounting.
- `out_char` and `out_last` hold stable while `out_val`&!`out_rdy`.

## Timing
- A capture in cycle t puts the first character on `out_val` in cycle t+1, with no combinational path from `cap_val` to `out_val`.
- With `out_rdy` held at 1, characters transfer in cycles t+1 … t+NCHARS and the separator in cycle t+NCHARS+1. `cap_rdy` returns in cycle t+NCHARS+2.
- Steady-state throughput is one line per NCHARS+2 cycles. There is no overlap of capture with the separator transfer.
- `cap_rdy` depends only on state and `reset`. `out_val` is a registered state decode.
- `reset` asserted in any state: the next cycle is IDLE with all outputs at reset values. A partial line is discarded without a separator.
- When NCHARS=1, EMIT lasts exactly one transfer.

## Structure
- Shared package `vc_trace_pkg` holds:
  - the state enum (IDLE, EMIT, SEP);
  - ASCII constants for SPACE, HASH, DOT, BAR and the digit/letter bases;
  - function `nibble_to_ascii(logic [3:0]) -> logic [7:0]`.
- Single flat module with no sub-module. The datapath is the capture registers, a $clog2(NCHARS)-bit down counter and a character mux.

## Test plan
All scenarios use p_msg_nbits=8 (NCHARS=2) and `out_rdy`=1 unless noted.
- Capture mon_val=1, mon_rdy=1, msg=0x3a: `3`(0x33), `a`(0x61), `|` in cycles t+1..t+3; `out_last` only on `|`; `cycles`=1; `cap_rdy`=1 at t+4.
- mon_val=0, mon_rdy=1: outputs 0x20, 0x20, 0x7C. mon_val=1, mon_rdy=0: outputs `#`, 0x20, `|`. mon_val=0, mon_rdy=0: outputs `.`, 0x20, `|`.
- Backpressure: `out_rdy` pattern 0,1,0,0,1,1 on msg 0xf0. `out_char` holds `f` across stalls; sequence is `f`,`0`,`|`; `cap_rdy`=0 until the cycle after the `|` transfer.
- `cap_val` held high through a whole line: exactly one capture per line, and `cycles` advances by 1 per line, never by the ignored requests.
- p_msg_nbits=10, msg=0x3ff: outputs `3`, `f`, `f`, `|`, confirming zero-extension of the top nibble.
- `reset` pulsed in the cycle after the first character transfer: next cycle `out_val`=0, `cycles`=0, `cap_rdy`=1 once `reset` drops; a fresh capture emits a full line.
